// File: rtl/seq_pattern_tx.sv
// Serial pattern transmitter: takes a parallel word over valid/ready and shifts it
// out one bit per clock on x, qualified by x_valid, with back-to-back, repeat and abort.
module seq_pattern_tx #(
  parameter int WIDTH      = 8,
  parameter bit MSB_FIRST  = 1'b1,
  parameter bit IDLE_LEVEL = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_valid,
  output logic             load_ready,
  input  logic [WIDTH-1:0] load_data,
  input  logic             repeat_en,
  input  logic             abort,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic             done,
  output logic [4:0]       bit_idx
);

  typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

  localparam logic [4:0] LAST_IDX = 5'(WIDTH - 1);

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] shift_reg, shift_next;
  logic [WIDTH-1:0] hold_reg, hold_next;
  logic [4:0]       idx_reg, idx_next;
  logic             x_reg, x_next;
  logic             done_reg, done_next;
  logic             accept;
  logic             last_bit;

  // The bit about to go out always sits at the "front" end of the shift register.
  function automatic logic first_bit(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? w[WIDTH-1] : w[0];
  endfunction

  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return MSB_FIRST ? {w[WIDTH-2:0], 1'b0} : {1'b0, w[WIDTH-1:1]};
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      shift_reg <= '0;
      hold_reg  <= '0;
      idx_reg   <= '0;
      x_reg     <= IDLE_LEVEL;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      shift_reg <= shift_next;
      hold_reg  <= hold_next;
      idx_reg   <= idx_next;
      x_reg     <= x_next;
      done_reg  <= done_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    shift_next = shift_reg;
    hold_next  = hold_reg;
    idx_next   = idx_reg;
    x_next     = x_reg;
    done_next  = 1'b0;
    unique case (state_reg)
      IDLE: begin
        x_next   = IDLE_LEVEL;
        idx_next = '0;
        if (accept) begin
          state_next = SHIFT;
          shift_next = load_data;
          hold_next  = load_data;
          x_next     = first_bit(load_data);
        end
      end
      SHIFT: begin
        if (abort) begin
          state_next = IDLE;
          idx_next   = '0;
          x_next     = IDLE_LEVEL;
        end else if (last_bit) begin
          // New word beats repeat; either way the next bit follows with no gap.
          idx_next = '0;
          if (accept) begin
            shift_next = load_data;
            hold_next  = load_data;
            x_next     = first_bit(load_data);
          end else if (repeat_en) begin
            shift_next = hold_reg;
            x_next     = first_bit(hold_reg);
          end else begin
            state_next = IDLE;
            x_next     = IDLE_LEVEL;
            done_next  = 1'b1;
          end
        end else begin
          shift_next = advance(shift_reg);
          x_next     = first_bit(advance(shift_reg));
          idx_next   = idx_reg + 5'd1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    last_bit   = (state_reg == SHIFT) && (idx_reg == LAST_IDX);
    load_ready = !abort && ((state_reg == IDLE) || last_bit);
    accept     = load_valid && load_ready;
    x          = x_reg;
    x_valid    = (state_reg == SHIFT);
    busy       = (state_reg == SHIFT);
    done       = done_reg;
    bit_idx    = idx_reg;
  end

  // A finished-word pulse can never overlap a data bit.
  assert property (@(posedge clk) disable iff (reset) !(done && x_valid));

endmodule

// File: tb/tb_seq_pattern_tx.sv
// Directed bench for seq_pattern_tx: MSB-first default instance plus an LSB-first,
// idle-high instance, checked cycle by cycle against hand-computed bit streams.
module tb_seq_pattern_tx;

  logic       clk = 1'b0;
  logic       reset;
  logic       load_valid, repeat_en, abort;
  logic [7:0] load_data;
  logic       load_ready, x, x_valid, busy, done;
  logic [4:0] bit_idx;

  logic       load_valid2, repeat_en2, abort2;
  logic [7:0] load_data2;
  logic       load_ready2, x2, x_valid2, busy2, done2;
  logic [4:0] bit_idx2;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  seq_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b1), .IDLE_LEVEL(1'b0)) dut (
    .clk(clk), .reset(reset), .load_valid(load_valid), .load_ready(load_ready),
    .load_data(load_data), .repeat_en(repeat_en), .abort(abort), .x(x),
    .x_valid(x_valid), .busy(busy), .done(done), .bit_idx(bit_idx)
  );

  seq_pattern_tx #(.WIDTH(8), .MSB_FIRST(1'b0), .IDLE_LEVEL(1'b1)) dut_lsb (
    .clk(clk), .reset(reset), .load_valid(load_valid2), .load_ready(load_ready2),
    .load_data(load_data2), .repeat_en(repeat_en2), .abort(abort2), .x(x2),
    .x_valid(x_valid2), .busy(busy2), .done(done2), .bit_idx(bit_idx2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expects bit 0 of w already on x; leaves the DUT showing bit 7 (no final tick).
  task automatic expect_word(input string tag, input logic [7:0] w);
    for (int i = 0; i < 8; i++) begin
      check({tag, ".x"},       x,          w[7-i]);
      check({tag, ".x_valid"}, x_valid,    1);
      check({tag, ".bit_idx"}, bit_idx,    i);
      check({tag, ".busy"},    busy,       1);
      check({tag, ".done"},    done,       0);
      check({tag, ".ready"},   load_ready, (i == 7));
      if (i < 7) tick();
    end
    $display("[TB] %s: word 0x%02h shifted out", tag, w);
  endtask

  task automatic expect_done(input string tag);
    check({tag, ".done"},    done,    1);
    check({tag, ".x_valid"}, x_valid, 0);
    check({tag, ".x"},       x,       0);
    check({tag, ".busy"},    busy,    0);
    tick();
    check({tag, ".done_end"}, done,       0);
    check({tag, ".ready"},    load_ready, 1);
  endtask

  initial begin
    reset = 1'b1;
    load_valid = 1'b0; load_data = '0; repeat_en = 1'b0; abort = 1'b0;
    load_valid2 = 1'b0; load_data2 = '0; repeat_en2 = 1'b0; abort2 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst.x",       x,          0);
    check("rst.x_valid", x_valid,    0);
    check("rst.busy",    busy,       0);
    check("rst.done",    done,       0);
    check("rst.bit_idx", bit_idx,    0);
    check("rst.ready",   load_ready, 1);
    check("rst.x2_idle", x2,         1);
    reset = 1'b0;
    tick();
    $display("[TB] reset state checked");

    // 1: single word
    load_valid = 1'b1; load_data = 8'hB4;
    tick();
    load_valid = 1'b0; load_data = 8'h00;
    expect_word("t1", 8'hB4);
    tick();
    expect_done("t1");

    // 2: back-to-back with load_valid held; 0x0F waits until the last-bit edge
    load_valid = 1'b1; load_data = 8'hB4;
    tick();
    load_data = 8'h0F;
    expect_word("t2a", 8'hB4);
    tick();
    load_valid = 1'b0;
    expect_word("t2b", 8'h0F);
    tick();
    expect_done("t2");

    // 3: repeat, dropped during the third copy
    repeat_en = 1'b1; load_valid = 1'b1; load_data = 8'hA5;
    tick();
    load_valid = 1'b0;
    expect_word("t3a", 8'hA5);
    tick();
    expect_word("t3b", 8'hA5);
    tick();
    tick();
    tick();
    repeat_en = 1'b0;
    check("t3c.bit_idx", bit_idx, 2);
    repeat (5) tick();
    check("t3c.last_idx", bit_idx, 7);
    check("t3c.last_x",   x,       1);
    check("t3c.done",     done,    0);
    tick();
    expect_done("t3");

    // 4: abort at bit 3, with a word offered during the abort
    load_valid = 1'b1; load_data = 8'hFF;
    tick();
    load_valid = 1'b0;
    repeat (3) tick();
    check("t4.bit_idx", bit_idx, 3);
    abort = 1'b1; load_valid = 1'b1; load_data = 8'h55;
    #1;
    check("t4.ready_abort", load_ready, 0);
    tick();
    check("t4.x_valid", x_valid,    0);
    check("t4.x",       x,          0);
    check("t4.busy",    busy,       0);
    check("t4.done",    done,       0);
    check("t4.ready_idle_abort", load_ready, 0);
    tick();
    check("t4.no_accept", x_valid, 0);
    check("t4.done2",     done,    0);
    abort = 1'b0; load_valid = 1'b0;
    #1;
    check("t4.ready_after", load_ready, 1);
    tick();
    check("t4.done3", done, 0);
    $display("[TB] t4: abort handled");

    // 5: async reset mid-word, between edges
    load_valid = 1'b1; load_data = 8'h96;
    tick();
    load_valid = 1'b0;
    repeat (5) tick();
    check("t5.bit_idx", bit_idx, 5);
    #2 reset = 1'b1;
    #1;
    check("t5.rst_x_valid", x_valid, 0);
    check("t5.rst_busy",    busy,    0);
    check("t5.rst_x",       x,       0);
    check("t5.rst_idx",     bit_idx, 0);
    tick();
    reset = 1'b0;
    check("t5.rst_done", done, 0);
    load_valid = 1'b1; load_data = 8'h3C;
    tick();
    load_valid = 1'b0;
    expect_word("t5", 8'h3C);
    tick();
    expect_done("t5");

    // 6: LSB-first, idle-high instance
    load_valid2 = 1'b1; load_data2 = 8'h01;
    tick();
    load_valid2 = 1'b0;
    for (int i = 0; i < 8; i++) begin
      check("t6.x",       x2,       (i == 0));
      check("t6.x_valid", x_valid2, 1);
      check("t6.bit_idx", bit_idx2, i);
      tick();
    end
    check("t6.idle_x",  x2,       1);
    check("t6.x_valid_end", x_valid2, 0);
    check("t6.done",    done2,    1);
    tick();
    check("t6.done_end", done2, 0);
    check("t6.idle_x2",  x2,    1);
    $display("[TB] t6: word 0x01 shifted LSB-first");

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
